// File: rtl/spi_ctrl_pkg.sv
// Shared types and defaults for the SPI request arbiter.
package spi_ctrl_pkg;

  localparam int unsigned BYTE_W      = 8;
  localparam int unsigned DEF_NUM_REQ = 2;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT,
    ST_RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request above last_grant, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   grant,
  output logic               any_req
);

  logic             w_found;
  logic [IDX_W-1:0] w_idx;

  assign any_req = |req;

  // Walk the requesters starting just after last_grant; the first hit wins.
  always_comb begin
    grant   = '0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = IDX_W'((32'(last_grant) + k) % NUM_REQ);
      if (!w_found && req[w_idx]) begin
        grant   = w_idx;
        w_found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_arbiter.sv
// Shares one SPI master among NUM_REQ byte requesters with round-robin
// grants, a done-edge detector and a WAIT timeout.
module spi_arbiter
  import spi_ctrl_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEF_NUM_REQ,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [BYTE_W*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]        ack,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [BYTE_W-1:0]         rsp_data,
  output logic                      rsp_timeout,
  output logic                      busy,
  output logic                      m_start,
  output logic [BYTE_W-1:0]         m_datain,
  input  logic                      m_done,
  input  logic [BYTE_W-1:0]         m_dataout
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned TMR_W = $clog2(TIMEOUT);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_grant;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   w_grant;
  logic               w_any_req;
  logic [TMR_W-1:0]   r_timer;
  logic               r_done_q;
  logic               r_tflag;
  logic               w_done_edge;
  logic               w_timer_hit;
  logic [BYTE_W-1:0]  w_bytes [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_bytes
    assign w_bytes[g] = req_data[g*BYTE_W +: BYTE_W];
  end

  // A level-high m_done only counts once: it must have been low last cycle.
  assign w_done_edge = m_done & ~r_done_q;
  assign w_timer_hit = (r_timer == TMR_W'(TIMEOUT - 1));

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req        (req),
    .last_grant (r_last_grant),
    .grant      (w_grant),
    .any_req    (w_any_req)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= ST_IDLE;
    else      r_state <= w_state_nxt;
  end

  // Next-state logic; a done edge takes priority over the timeout.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_any_req) w_state_nxt = ST_START;
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT:  if (w_done_edge || w_timer_hit) w_state_nxt = ST_RESP;
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Registered outputs, grant bookkeeping, timer and done-edge history.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ack          <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
      rsp_timeout  <= 1'b0;
      busy         <= 1'b0;
      m_start      <= 1'b0;
      m_datain     <= '0;
      r_grant      <= '0;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_timer      <= '0;
      r_done_q     <= 1'b0;
      r_tflag      <= 1'b0;
    end else begin
      ack       <= '0;
      rsp_valid <= '0;
      m_start   <= 1'b0;
      r_done_q  <= m_done;
      busy      <= (w_state_nxt != ST_IDLE);
      case (r_state)
        ST_IDLE: begin
          if (w_any_req) begin
            r_grant  <= w_grant;
            m_datain <= w_bytes[w_grant];
            ack      <= NUM_REQ'(1) << w_grant;
          end
        end
        ST_START: begin
          m_start <= 1'b1;
          r_timer <= '0;
        end
        ST_WAIT: begin
          if (w_done_edge) begin
            rsp_data <= m_dataout;
            r_tflag  <= 1'b0;
          end else if (w_timer_hit) begin
            rsp_data <= '0;
            r_tflag  <= 1'b1;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        ST_RESP: begin
          rsp_valid    <= NUM_REQ'(1) << r_grant;
          rsp_timeout  <= r_tflag;
          r_last_grant <= r_grant;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_arbiter.sv
// Self-checking bench for spi_arbiter: directed table, held-done and reset
// sequences, and randomized transfers against a transaction-level model.
module tb_spi_arbiter;
  import spi_ctrl_pkg::*;

  localparam int unsigned NR = 2;
  localparam int unsigned TO = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req;
  logic [8*NR-1:0]   req_data;
  logic [NR-1:0]     ack;
  logic [NR-1:0]     rsp_valid;
  logic [7:0]        rsp_data;
  logic              rsp_timeout;
  logic              busy;
  logic              m_start;
  logic [7:0]        m_datain;
  logic              m_done;
  logic [7:0]        m_dataout;

  int checks   = 0;
  int failures = 0;
  int m_last;

  spi_arbiter #(.NUM_REQ(NR), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .rsp_timeout (rsp_timeout),
    .busy        (busy),
    .m_start     (m_start),
    .m_datain    (m_datain),
    .m_done      (m_done),
    .m_dataout   (m_dataout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Round-robin rule: first requester above the last grant, wrapping.
  function automatic int rr_pick(input logic [NR-1:0] rq, input int last);
    for (int k = 1; k <= int'(NR); k++) begin
      if ((rq & (NR'(1) << ((last + k) % NR))) != '0) return (last + k) % NR;
    end
    return -1;
  endfunction

  // Index j (cycles after the m_start cycle) of the first m_done rise that
  // lands inside the TO-cycle wait window, or -1 if the transfer times out.
  function automatic int resp_step(input logic lvl0, input logic [63:0] mask);
    logic lvl = lvl0;
    for (int j = 0; j < int'(TO); j++) begin
      logic b = 1'(mask >> j);
      if (b && !lvl) return j;
      lvl = b;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst = 1'b0; req = '0; req_data = '0; m_done = 1'b0; m_dataout = '0;
    repeat (2) @(negedge clk);
    chk("rst_ack", ack, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_timeout", rsp_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_m_start", m_start, 0);
    chk("rst_m_datain", m_datain, 0);
    rst = 1'b1;
    m_last = NR - 1;
    @(negedge clk);
  endtask

  // One full transfer: request, ack, start pulse, master behaviour from mask,
  // response. exp_wait < 0 skips the ack-latency check.
  task automatic xfer(input logic [NR-1:0] rq, input logic [15:0] d, input logic [63:0] mask,
                      input logic [7:0] sresp, input bit keep_req, input int exp_wait,
                      input int exp_g, input logic [7:0] exp_d, input logic exp_to);
    int n, g, j, exp_i, last_i;
    logic [7:0] dsent;
    bit seen;
    req = rq; req_data = d; n = 0;
    while (ack == '0 && n < 40) begin
      @(negedge clk); n++;
    end
    if (ack == '0) begin
      chk("ack_wait_expired", 0, 1);
      req = '0;
      return;
    end
    if (exp_wait >= 0) chk("ack_latency", n, exp_wait);
    chk("ack_onehot", 32'($onehot(ack)), 1);
    g = -1;
    for (int i = 0; i < int'(NR); i++) if (ack == (NR'(1) << i)) g = i;
    chk("ack_index", g, exp_g);
    dsent = 8'(d >> (8 * exp_g));
    if (!keep_req) req = '0;
    @(negedge clk);
    chk("m_start", m_start, 1);
    chk("ack_pulse", ack, 0);
    chk("m_datain", m_datain, dsent);
    chk("busy", busy, 1);
    j = resp_step(m_done, mask);
    exp_i = (j < 0) ? int'(TO) + 1 : j + 2;
    seen = 0; last_i = 0;
    for (int i = 1; i <= int'(TO) + 4; i++) begin
      if (seen) break;
      m_done = 1'(mask >> (i - 1)); m_dataout = sresp;
      @(negedge clk); last_i = i;
      if (i == 1) chk("m_start_pulse", m_start, 0);
      if (rsp_valid != '0) begin
        seen = 1;
        chk("rsp_latency", i, exp_i);
        chk("rsp_index", rsp_valid, NR'(1) << exp_g);
        chk("rsp_data", rsp_data, exp_d);
        chk("rsp_timeout", rsp_timeout, exp_to);
      end else begin
        chk("m_datain_hold", m_datain, dsent);
      end
    end
    if (!seen) chk("rsp_wait_expired", 0, 1);
    m_done = 1'(mask >> last_i);
    @(negedge clk);
    chk("rsp_pulse", rsp_valid, 0);
    chk("rsp_data_hold", rsp_data, exp_d);
    chk("rsp_to_hold", rsp_timeout, exp_to);
  endtask

  typedef struct {
    logic [NR-1:0] rq;
    logic [15:0]   d;
    logic [63:0]   mask;
    logic [7:0]    sresp;
    int            eg;
    logic [7:0]    ed;
    logic          eto;
  } vec_t;

  initial begin
    vec_t tbl [7];
    tbl[0] = '{2'b01, 16'h00A5, 64'h4,        8'h5A, 0, 8'h5A, 1'b0};
    tbl[1] = '{2'b10, 16'h3C00, 64'h1,        8'hC3, 1, 8'hC3, 1'b0};
    tbl[2] = '{2'b11, 16'h2211, 64'h2,        8'h77, 0, 8'h77, 1'b0};
    tbl[3] = '{2'b11, 16'h2211, 64'h10,       8'h88, 1, 8'h88, 1'b0};
    tbl[4] = '{2'b01, 16'h00EE, 64'h0,        8'hAB, 0, 8'h00, 1'b1};
    tbl[5] = '{2'b10, 16'h4400, 64'h8000,     8'h99, 1, 8'h99, 1'b0};
    tbl[6] = '{2'b10, 16'h5500, 64'h10000,    8'h66, 1, 8'h00, 1'b1};

    do_reset();

    for (int t = 0; t < 7; t++) begin
      xfer(tbl[t].rq, tbl[t].d, tbl[t].mask, tbl[t].sresp, 1'b0, 1,
           tbl[t].eg, tbl[t].ed, tbl[t].eto);
      m_last = tbl[t].eg;
    end

    // m_done held for three cycles gives one response; the next transfer
    // enters WAIT with m_done still high and must wait for a fresh rise.
    m_done = 1'b0;
    xfer(2'b01, 16'h0031, 64'h7, 8'h42, 1'b0, 1, 0, 8'h42, 1'b0);
    chk("done_still_high", m_done, 1);
    xfer(2'b10, 16'h3200, 64'h4F, 8'h24, 1'b0, 1, 1, 8'h24, 1'b0);
    m_last = 1;
    m_done = 1'b0;

    // Randomized transfers against the round-robin / done-edge model.
    for (int it = 0; it < 40; it++) begin
      logic [NR-1:0] rq;
      logic [15:0]   d;
      logic [63:0]   mask;
      logic [7:0]    sresp;
      int            eg, js;
      rq    = NR'($urandom_range(1, 3));
      d     = 16'($urandom);
      sresp = 8'($urandom);
      if ($urandom_range(0, 9) == 0) mask = '0;
      else mask = ((64'd1 << $urandom_range(1, 4)) - 64'd1) << $urandom_range(0, 12);
      m_done = 1'b0;
      eg = rr_pick(rq, m_last);
      js = resp_step(1'b0, mask);
      xfer(rq, d, mask, sresp, 1'b0, 1, eg,
           (js < 0) ? 8'h00 : sresp, (js < 0) ? 1'b1 : 1'b0);
      m_last = eg;
    end
    m_done = 1'b0;

    // Reset while waiting for the master: immediate clear, no response.
    req = 2'b01; req_data = 16'h00C7;
    for (int n = 0; n < 40 && m_start !== 1'b1; n++) begin
      @(negedge clk);
      if (ack != '0) req = '0;
    end
    chk("pre_reset_m_start", m_start, 1);
    #2 rst = 1'b0;
    #1;
    chk("async_m_start", m_start, 0);
    chk("async_busy", busy, 0);
    chk("async_m_datain", m_datain, 0);
    chk("async_rsp_data", rsp_data, 0);
    chk("async_ack", ack, 0);
    for (int n = 0; n < 3; n++) begin
      m_done = (n == 1); m_dataout = 8'hEE;
      @(negedge clk);
      chk("reset_no_rsp", rsp_valid, 0);
    end
    m_done = 1'b0;
    rst = 1'b1;
    m_last = NR - 1;
    @(negedge clk);
    xfer(2'b10, 16'hB700, 64'h8, 8'h3D, 1'b0, 1, rr_pick(2'b10, m_last), 8'h3D, 1'b0);

    // Both requesters held from reset: grants alternate 0,1,0,1.
    do_reset();
    xfer(2'b11, 16'h2211, 64'h2, 8'h60, 1'b1, 1, 0, 8'h60, 1'b0);
    xfer(2'b11, 16'h2211, 64'h2, 8'h61, 1'b1, 0, 1, 8'h61, 1'b0);
    xfer(2'b11, 16'h2211, 64'h2, 8'h62, 1'b1, 0, 0, 8'h62, 1'b0);
    xfer(2'b11, 16'h2211, 64'h2, 8'h63, 1'b1, 0, 1, 8'h63, 1'b0);
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
